clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time programmable clock divider controller. Produces a divided clock
//  (out_clk) and a one-cycle clock-enable strobe (tick) from clk.
//  Divisor changes and start/stop requests take effect only at period
//  boundaries, so out_clk never has runt pulses.
//  Sits between the config/register interface and the clock-enable consumers.
//  Supersedes the fixed divide-by-2 flop wherever the ratio must change at run time.
// PARAMETERS
//  CNT_W    8  width of divisor and period counter
//  DEF_DIV  2  divisor loaded at reset; must be in 2..2^CNT_W-1
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-low reset
//  en         in   1      level; 1 = run divider, 0 = stop at end of current period
//  cfg_valid  in   1      new divisor offered
//  cfg_div    in   CNT_W  requested divisor N
//  cfg_ready  out  1      controller can accept cfg (= ~pend_vld)
//  cfg_err    out  1      1-cycle pulse: accepted cfg had N<2, ignored
//  out_clk    out  1      divided clock, registered
//  tick       out  1      1-cycle pulse coincident with each out_clk rising edge
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, any time incl. mid-period): state=IDLE, cnt=0, div_r=DEF_DIV,
//    pend_vld=0, out_clk=0, tick=0, cfg_err=0. busy=0 and cfg_ready=1 follow from state.
//  - Handshake: cfg is accepted when cfg_valid & cfg_ready.
//    N<2: cfg_err=1 next cycle, no other state change.
//  - IDLE: accepted cfg is written directly to div_r.
//    en=1 -> RUN next edge with cnt=0, out_clk=1, tick=1 (1-cycle latency).
//    Cfg accepted in the same cycle as en applies to the first period.
//  - Period: cnt counts 0..div_r-1 and wraps.
//    out_clk=1 for cnt < div_r>>1, else 0.
//    Each period = div_r cycles, high for floor(N/2) cycles, low for ceil(N/2).
//    tick=1 exactly on cycles where cnt==0 in RUN/DRAIN.
//  - RUN: accepted cfg is stored in pend_div, pend_vld=1, cfg_ready=0.
//    At boundary (cnt==div_r-1): div_r<=pend_div, pend_vld<=0.
//    Cfg accepted ON the boundary cycle applies at the following boundary.
//  - RUN & en=0 -> DRAIN; current period completes unchanged.
//  - DRAIN: at boundary -> IDLE, cnt=0, out_clk=0, no tick.
//    en=1 again before boundary -> RUN with no break in the waveform.
//    Pending cfg still applies at the boundary (also when going to IDLE).
//  - cnt arithmetic: unsigned CNT_W bits; compare uses div_r-1. No overflow,
//    since div_r >= 2.
//  - All outputs are registered or decoded from state only; no input->output
//    combinational path.
// STRUCTURE
//  - clk_div_pkg: state enum {IDLE, RUN, DRAIN} (2-bit), localparam MIN_DIV=2.
//  - Sub-module clk_div_counter: cnt, wrap detect, out_clk/tick generation.
//    Inputs: run, div_r. Outputs: boundary, out_clk, tick.
//  - Top: FSM, cfg handshake, pend/div registers.
// TESTING
//  1 rst release, en=1 -> tick 1 cycle after en; out_clk 1,0,1,0 (period 2);
//    busy=1.
//  2 IDLE cfg N=5, then en=1 -> out_clk high 2 / low 3; tick every 5 cycles.
//  3 RUN N=4, cfg N=6 at cnt=1 -> cfg_ready=0 until boundary; that period
//    is 4 cycles, later periods 6.
//  4 cfg N=1 (and N=0) -> cfg_err pulse 1 cycle; div_r and waveform unchanged.
//  5 RUN N=4, en=0 at cnt=1 -> period completes (2 high, 2 low); busy=0 after
//    cnt=3; no partial pulse. Second run: en=0 then en=1 before boundary ->
//    continuous waveform.
//  6 rst asserted mid high phase (N=6) -> out_clk=0 and tick=0 immediately;
//    after release + en, period 2 (DEF_DIV).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time programmable clock divider.
// The state enum is used by the controller FSM; MIN_DIV is the smallest legal divisor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_counter.sv
// Period counter for the clock divider: wrap detection plus registered out_clk/tick.
// Outputs are registered from next-cycle values so they line up with the count.
module clk_div_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             run,
    input  logic [CNT_W-1:0] div_cur,
    input  logic [CNT_W-1:0] div_next,
    output logic             boundary,
    output logic             out_clk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             out_clk_reg;
    logic             tick_reg;

    // div_cur >= 2 whenever active, so the subtraction never wraps.
    assign boundary = active && (cnt_reg == (div_cur - CNT_W'(1)));

    always_comb begin
        cnt_next = '0;
        if (run && active && !boundary) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            out_clk_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            out_clk_reg <= run && (cnt_next < (div_next >> 1));
            tick_reg    <= run && (cnt_next == '0);
        end
    end

    assign out_clk = out_clk_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider controller: FSM, divisor handshake and
// pending-divisor register; divisor and stop requests only act at period boundaries.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             out_clk,
    output logic             tick,
    output logic             busy
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] pend_div_reg;
    logic             pend_vld_reg;
    logic             cfg_err_reg;
    logic             accept;
    logic             cfg_ok;
    logic             active;
    logic             run;
    logic             boundary;

    assign accept = cfg_valid && !pend_vld_reg;
    assign cfg_ok = (cfg_div >= CNT_W'(MIN_DIV));
    assign active = (state_reg != IDLE);
    assign run    = (state_next != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stopping is decided on the last cycle of a period: low en there ends the run.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN, DRAIN: begin
                if (boundary && !en) begin
                    state_next = IDLE;
                end else if (en) begin
                    state_next = RUN;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_comb begin
        div_next = div_reg;
        if (!active) begin
            if (accept && cfg_ok) begin
                div_next = cfg_div;
            end
        end else if (boundary && pend_vld_reg) begin
            div_next = pend_div_reg;
        end
    end

    // A pending divisor blocks new offers, so boundary apply and accept never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg      <= CNT_W'(DEF_DIV);
            pend_div_reg <= '0;
            pend_vld_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            div_reg     <= div_next;
            cfg_err_reg <= accept && !cfg_ok;
            if (active && boundary) begin
                pend_vld_reg <= 1'b0;
            end
            if (active && accept && cfg_ok) begin
                pend_vld_reg <= 1'b1;
                pend_div_reg <= cfg_div;
            end
        end
    end

    clk_div_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .run      (run),
        .div_cur  (div_reg),
        .div_next (div_next),
        .boundary (boundary),
        .out_clk  (out_clk),
        .tick     (tick)
    );

    assign cfg_ready = !pend_vld_reg;
    assign cfg_err   = cfg_err_reg;

endmodule
